// File: rtl/cgra_seq_pkg.sv
// Shared definitions for the CGRA instruction sequencer: default widths
// and the sequencer state encoding.
package cgra_seq_pkg;

    localparam int DEF_INST_DWIDTH = 72;
    localparam int DEF_INST_AWIDTH = 10;
    localparam int DEF_LOOP_WIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/inst_ram.sv
// Instruction store: simple dual-port RAM with one write port and one
// synchronous read port (1-cycle latency). Only the read register is
// reset, so program contents survive a sequencer reset.
module inst_ram #(
    parameter int DWIDTH = 72,
    parameter int AWIDTH = 10
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [AWIDTH-1:0] i_wr_addr,
    input  logic [DWIDTH-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AWIDTH-1:0] i_rd_addr,
    output logic [DWIDTH-1:0] o_rd_data
);

    logic [DWIDTH-1:0] r_mem [0:(2**AWIDTH)-1];
    logic [DWIDTH-1:0] r_rd_data;

    // Host write port; no reset so the array stays block-RAM inferable.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read register only updates on a fetch, so it holds the last word while stalled.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/inst_sequencer.sv
// Instruction sequencer: plays a preloaded program of Prog_Len words
// Loop_Num+1 times into the PE array, honouring Stall and Abort.
module inst_sequencer
    import cgra_seq_pkg::*;
#(
    parameter int INST_DWIDTH = DEF_INST_DWIDTH,
    parameter int INST_AWIDTH = DEF_INST_AWIDTH,
    parameter int LOOP_WIDTH  = DEF_LOOP_WIDTH
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Wr_En,
    input  logic [INST_AWIDTH-1:0] Wr_Addr,
    input  logic [INST_DWIDTH-1:0] Wr_Data,
    output logic                   Wr_Err,
    input  logic                   Start,
    input  logic                   Abort,
    input  logic [INST_AWIDTH:0]   Prog_Len,
    input  logic [LOOP_WIDTH-1:0]  Loop_Num,
    input  logic                   Stall,
    output logic [INST_DWIDTH-1:0] Inst_Out,
    output logic                   Inst_Valid,
    output logic                   Busy,
    output logic                   Done
);

    localparam logic [INST_AWIDTH:0]  ADDR_ONE = {{INST_AWIDTH{1'b0}}, 1'b1};
    localparam logic [LOOP_WIDTH-1:0] PASS_ONE = {{(LOOP_WIDTH-1){1'b0}}, 1'b1};

    seq_state_t              r_state;
    logic [INST_AWIDTH:0]    r_addr;
    logic [INST_AWIDTH:0]    r_len;
    logic [LOOP_WIDTH-1:0]   r_pass;
    logic [LOOP_WIDTH-1:0]   r_loop;
    logic                    r_valid;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_wr_err;

    logic                    w_issue;
    logic                    w_last;
    logic                    w_wr_ok;
    logic [INST_AWIDTH:0]    w_last_addr;

    // A fetch is issued every RUN cycle unless the array stalls or the run is aborted.
    assign w_issue     = (r_state == ST_RUN) && !Stall && !Abort;
    assign w_last_addr = r_len - ADDR_ONE;
    assign w_last      = (r_addr == w_last_addr);
    // Program loads are only accepted while idle; reset blocks them.
    assign w_wr_ok     = Wr_En && (r_state == ST_IDLE) && !Reset;

    inst_ram #(
        .DWIDTH (INST_DWIDTH),
        .AWIDTH (INST_AWIDTH)
    ) u_inst_ram (
        .i_clk     (Clk),
        .i_reset   (Reset),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (Wr_Addr),
        .i_wr_data (Wr_Data),
        .i_rd_en   (w_issue),
        .i_rd_addr (r_addr[INST_AWIDTH-1:0]),
        .o_rd_data (Inst_Out)
    );

    // Sequencer FSM with its registered status outputs and address/pass counters.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_len    <= '0;
            r_pass   <= '0;
            r_loop   <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_valid  <= w_issue;
            r_wr_err <= Wr_En && (r_state != ST_IDLE);
            r_done   <= 1'b0;
            if (Abort && (r_state != ST_IDLE)) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (Start && !Abort) begin
                            r_len  <= Prog_Len;
                            r_loop <= Loop_Num;
                            r_addr <= '0;
                            r_pass <= '0;
                            r_busy <= 1'b1;
                            if (Prog_Len == '0) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (w_issue) begin
                            if (w_last) begin
                                if (r_pass < r_loop) begin
                                    r_addr <= '0;
                                    r_pass <= r_pass + PASS_ONE;
                                end else begin
                                    r_state <= ST_DRAIN;
                                end
                            end else begin
                                r_addr <= r_addr + ADDR_ONE;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Inst_Valid = r_valid;
    assign Busy       = r_busy;
    assign Done       = r_done;
    assign Wr_Err     = r_wr_err;

endmodule
